// File: rtl/cmd_gen_pkg.sv
// Shared types, default widths and stage helpers for the serial command generator.
package cmd_gen_pkg;

    localparam int CMD_W_DEF     = 8;
    localparam int CNT_W_DEF     = 16;
    localparam int STAGE_LEN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        S4
    } stage_e;

    // One-hot stage indicator vector {stage4, stage3, stage2, stage1} for a state.
    function automatic logic [3:0] stage_onehot(input stage_e s);
        case (s)
            S1:      return 4'b0001;
            S2:      return 4'b0010;
            S3:      return 4'b0100;
            S4:      return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Successor of a stage once its dwell time has elapsed.
    function automatic stage_e stage_next(input stage_e s);
        case (s)
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cmd_gen_if.sv
// Serial input and sequencer output bundle of the command generator.
interface cmd_gen_if
    import cmd_gen_pkg::*;
#(
    parameter int CMD_W = CMD_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             data_in;
    logic             strobe_in;
    logic [CMD_W-1:0] cmd_type;
    logic [CNT_W-1:0] clk_cnt;
    logic             stage1;
    logic             stage2;
    logic             stage3;
    logic             stage4;

    modport master (
        output data_in,
        output strobe_in,
        input  cmd_type,
        input  clk_cnt,
        input  stage1,
        input  stage2,
        input  stage3,
        input  stage4
    );

    modport slave (
        input  data_in,
        input  strobe_in,
        output cmd_type,
        output clk_cnt,
        output stage1,
        output stage2,
        output stage3,
        output stage4
    );

endinterface

// File: rtl/cmd_gen_shift.sv
// Strobe edge detector, MSB-first shift register and bit counter.
// cmd_done / cmd_word are valid in the cycle of the last qualifying edge so the
// parent can register the command on that same clock edge.
module cmd_gen_shift
    import cmd_gen_pkg::*;
#(
    parameter int CMD_W = CMD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             strobe_in,
    output logic             cmd_done,
    output logic [CMD_W-1:0] cmd_word
);

    localparam int BC_W = $clog2(CMD_W);

    logic             strobe_q;
    // Only the CMD_W-1 older bits are stored; the newest bit comes straight from data_in.
    logic [CMD_W-2:0] sr;
    logic [BC_W-1:0]  bit_cnt;
    logic             rise;
    logic             last_bit;

    assign rise     = strobe_in & ~strobe_q;
    assign last_bit = (bit_cnt == BC_W'(CMD_W - 1));
    assign cmd_done = rise & last_bit;
    assign cmd_word = {sr, data_in};

    // Track strobe history and shift one bit in per rising strobe edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            sr       <= '0;
            bit_cnt  <= '0;
        end else begin
            strobe_q <= strobe_in;
            if (rise) begin
                sr      <= cmd_word[CMD_W-2:0];
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_generator.sv
// Serial command receiver with a four-stage one-hot sequencer and free-running
// cycle counter. rst_n keeps its legacy name but is asynchronous active-high.
module cmd_generator
    import cmd_gen_pkg::*;
#(
    parameter int CMD_W     = CMD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int STAGE_LEN = STAGE_LEN_DEF
) (
    input logic     clk,
    input logic     rst_n,
    cmd_gen_if.slave bus
);

    localparam int DW_W = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;

    logic             cmd_done;
    logic [CMD_W-1:0] cmd_word;

    logic [CNT_W-1:0] cnt;
    logic [CMD_W-1:0] cmd_reg;
    logic [3:0]       stage_vec;
    logic [DW_W-1:0]  dwell;
    stage_e           state;

    cmd_gen_shift #(
        .CMD_W(CMD_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst_n),
        .data_in  (bus.data_in),
        .strobe_in(bus.strobe_in),
        .cmd_done (cmd_done),
        .cmd_word (cmd_word)
    );

    // Free-running timestamp counter, wraps silently.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Command latch and stage sequencer; a completed command always restarts at S1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            dwell     <= '0;
            stage_vec <= '0;
            cmd_reg   <= '0;
        end else if (cmd_done) begin
            cmd_reg   <= cmd_word;
            state     <= S1;
            dwell     <= '0;
            stage_vec <= stage_onehot(S1);
        end else if (state != IDLE) begin
            if (dwell == DW_W'(STAGE_LEN - 1)) begin
                state     <= stage_next(state);
                dwell     <= '0;
                stage_vec <= stage_onehot(stage_next(state));
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign bus.cmd_type = cmd_reg;
    assign bus.clk_cnt  = cnt;
    assign bus.stage1   = stage_vec[0];
    assign bus.stage2   = stage_vec[1];
    assign bus.stage3   = stage_vec[2];
    assign bus.stage4   = stage_vec[3];

endmodule

// File: tb/tb_cmd_generator.sv
// Directed bench for cmd_generator: a default instance plus a STAGE_LEN=10
// instance sharing the same serial stream, so a restart lands mid-S2.
module tb_cmd_generator;
    import cmd_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cmd_gen_if #(.CMD_W(8), .CNT_W(16)) bus ();
    cmd_gen_if #(.CMD_W(8), .CNT_W(16)) bus_l ();

    assign bus_l.data_in   = bus.data_in;
    assign bus_l.strobe_in = bus.strobe_in;

    cmd_generator #(
        .CMD_W(8),
        .CNT_W(16),
        .STAGE_LEN(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    cmd_generator #(
        .CMD_W(8),
        .CNT_W(16),
        .STAGE_LEN(10)
    ) dut_l (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_l.slave)
    );

    logic [3:0] stg_m;
    logic [3:0] stg_l;
    assign stg_m = {bus.stage4, bus.stage3, bus.stage2, bus.stage1};
    assign stg_l = {bus_l.stage4, bus_l.stage3, bus_l.stage2, bus_l.stage1};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sends v[n-1:0] MSB first, one strobe pulse per bit; returns on the negedge
    // right after the last bit's sampling edge with the strobe still high.
    task automatic send_bits(input logic [7:0] v, input int unsigned n);
        for (int i = int'(n) - 1; i >= 0; i--) begin
            bus.data_in   = v[i];
            bus.strobe_in = 1'b1;
            @(negedge clk);
            if (i != 0) begin
                bus.strobe_in = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [3:0] exp_stg;

        bus.data_in   = 1'b0;
        bus.strobe_in = 1'b0;

        // Reset held, then released: counter runs from zero.
        repeat (4) @(negedge clk);
        check("rst_cmd", 32'(bus.cmd_type), 32'h0);
        check("rst_cnt", 32'(bus.clk_cnt), 32'h0);
        check("rst_stg", 32'(stg_m), 32'h0);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("cnt10", 32'(bus.clk_cnt), 32'd10);

        // 0xA5 then the full stage sequence, sampled every cycle.
        send_bits(8'hA5, 8);
        bus.strobe_in = 1'b0;
        check("a5_cmd", 32'(bus.cmd_type), 32'hA5);
        for (int k = 0; k < 18; k++) begin
            exp_stg = (k < 16) ? (4'b0001 << (k / 4)) : 4'b0000;
            check("a5_seq", 32'(stg_m), 32'(exp_stg));
            @(negedge clk);
        end

        // Strobe held 40 cycles with data toggling yields a single 0 bit.
        bus.data_in   = 1'b0;
        bus.strobe_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.data_in = ~bus.data_in;
        end
        bus.strobe_in = 1'b0;
        @(negedge clk);
        check("hold_cmd", 32'(bus.cmd_type), 32'hA5);
        check("hold_stg", 32'(stg_m), 32'h0);
        send_bits(8'h7F, 7);
        bus.strobe_in = 1'b0;
        check("hold_one_bit", 32'(bus.cmd_type), 32'h7F);
        check("hold_s1", 32'(stg_m), 32'b0001);
        repeat (45) @(negedge clk);

        // 0x11 completes 16 cycles after 0xA5: main instance at end of S4,
        // long instance mid-S2; both restart at S1.
        send_bits(8'hA5, 8);
        bus.strobe_in = 1'b0;
        @(negedge clk);
        send_bits(8'h11, 8);
        bus.strobe_in = 1'b0;
        check("re_cmd", 32'(bus.cmd_type), 32'h11);
        check("re_cmd_l", 32'(bus_l.cmd_type), 32'h11);
        for (int j = 0; j < 11; j++) begin
            exp_stg = (j < 4) ? 4'b0001 : ((j < 8) ? 4'b0010 : 4'b0100);
            check("re_seq", 32'(stg_m), 32'(exp_stg));
            exp_stg = (j < 10) ? 4'b0001 : 4'b0010;
            check("re_seq_l", 32'(stg_l), 32'(exp_stg));
            @(negedge clk);
        end
        repeat (45) @(negedge clk);

        // Reset in S3 with three partial bits pending, then a clean 0x3C.
        send_bits(8'hA5, 8);
        bus.strobe_in = 1'b0;
        @(negedge clk);
        send_bits(8'h07, 3);
        bus.strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_s3", 32'(stg_m), 32'b0100);
        #2 rst_n = 1'b1;
        #1;
        check("async_cmd", 32'(bus.cmd_type), 32'h0);
        check("async_cnt", 32'(bus.clk_cnt), 32'h0);
        check("async_stg", 32'(stg_m), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        send_bits(8'h3C, 8);
        bus.strobe_in = 1'b0;
        check("clean_cmd", 32'(bus.cmd_type), 32'h3C);
        check("clean_s1", 32'(stg_m), 32'b0001);

        // Counter wrap after 65536 cycles from release.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (65535) @(negedge clk);
        check("cnt_max", 32'(bus.clk_cnt), 32'hFFFF);
        @(negedge clk);
        check("cnt_wrap", 32'(bus.clk_cnt), 32'h0);
        @(negedge clk);
        check("cnt_after", 32'(bus.clk_cnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
